k_sync_fifo_fwft: RTL and testbench



---
 rtl/k_sync_fifo_fwft.sv | 76 +++++++
 tb/tb_k_sync_fifo_fwft.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/k_sync_fifo_fwft.sv
// rtl/k_sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO with occupancy and error flags
// Head word is read combinationally from storage, so a write is visible on q right after its edge.
module k_sync_fifo_fwft #(
  parameter int data_size    = 8,
  parameter int addr_size    = 2,
  parameter int afull_level  = 2**addr_size - 1,
  parameter int aempty_level = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [data_size-1:0] d,
  input  logic                 wen,
  input  logic                 ren,
  output logic [data_size-1:0] q,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [addr_size:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 2**addr_size;
  localparam logic [addr_size:0] afull_thr  = (addr_size+1)'(afull_level);
  localparam logic [addr_size:0] aempty_thr = (addr_size+1)'(aempty_level);
  localparam logic [addr_size:0] ptr_one    = (addr_size+1)'(1);

  logic [data_size-1:0] mem [DEPTH];
  logic [addr_size:0]   wptr;
  logic [addr_size:0]   rptr;
  logic                 wr_ok;
  logic                 rd_ok;

  // The MSB of each pointer is a wrap bit that separates full from empty.
  assign empty        = (wptr == rptr);
  assign full         = (wptr[addr_size-1:0] == rptr[addr_size-1:0]) &&
                        (wptr[addr_size] != rptr[addr_size]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= afull_thr);
  assign almost_empty = (count <= aempty_thr);

  assign wr_ok = wen && !full;
  assign rd_ok = ren && !empty;

  assign q = mem[rptr[addr_size-1:0]];

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wptr[addr_size-1:0]] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + ptr_one;
      end
      if (rd_ok) begin
        rptr <= rptr + ptr_one;
      end
      if (wen && full) begin
        overflow <= 1'b1;
      end
      if (ren && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_k_sync_fifo_fwft.sv
// tb/tb_k_sync_fifo_fwft.sv - scoreboard bench for k_sync_fifo_fwft at depth 4 and depth 2
module tb_k_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d = '0, d1 = '0;
  logic       wen = 1'b0, ren = 1'b0, wen1 = 1'b0, ren1 = 1'b0;
  logic [7:0] q, q1;
  logic       empty, full, almost_full, almost_empty, overflow, underflow;
  logic       empty1, full1, almost_full1, almost_empty1, overflow1, underflow1;
  logic [2:0] count;
  logic [1:0] count1;

  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  bit         ovf_a, udf_a, ovf_b, udf_b;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  k_sync_fifo_fwft #(.data_size(8), .addr_size(2)) dut (
    .clk(clk), .rst(rst), .d(d), .wen(wen), .ren(ren), .q(q),
    .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  k_sync_fifo_fwft #(.data_size(8), .addr_size(1)) dut1 (
    .clk(clk), .rst(rst), .d(d1), .wen(wen1), .ren(ren1), .q(q1),
    .empty(empty1), .full(full1), .almost_full(almost_full1), .almost_empty(almost_empty1),
    .count(count1), .overflow(overflow1), .underflow(underflow1)
  );

  // One clock edge; models advance from pre-edge occupancy, outputs are sampled 1 time unit later.
  task automatic cyc();
    int na = sb_a.size();
    int nb = sb_b.size();
    @(posedge clk);
    if (rst) begin
      sb_a.delete(); sb_b.delete();
      ovf_a = 0; udf_a = 0; ovf_b = 0; udf_b = 0;
    end else begin
      if (wen && na == 4) ovf_a = 1;
      if (ren && na == 0) udf_a = 1;
      if (ren && na > 0) void'(sb_a.pop_front());
      if (wen && na < 4) sb_a.push_back(d);
      if (wen1 && nb == 2) ovf_b = 1;
      if (ren1 && nb == 0) udf_b = 1;
      if (ren1 && nb > 0) void'(sb_b.pop_front());
      if (wen1 && nb < 2) sb_b.push_back(d1);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks += 7;
    if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b expected 1", almost_empty); end
    if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b expected 0", almost_full); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_udf: got %b expected 0", underflow); end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      d = vals[i]; wen = 1'b1;
      cyc();
      n_checks += 5;
      if (count !== 3'(sb_a.size())) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, sb_a.size()); end
      if (q !== 8'h11) begin n_fail++; $display("FAIL fill_q[%0d]: got %h expected 11", i, q); end
      if (almost_full !== (i + 1 >= 3)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, almost_full, i + 1 >= 3); end
      if (full !== (i == 3)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, i == 3); end
      if (almost_empty !== (i + 1 <= 1)) begin n_fail++; $display("FAIL fill_aempty[%0d]: got %b expected %b", i, almost_empty, i + 1 <= 1); end
    end
    wen = 1'b0;
  endtask

  task automatic test_overflow();
    d = 8'h55; wen = 1'b1;
    cyc();
    wen = 1'b0;
    n_checks += 2;
    if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", count); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (q !== sb_a[0]) begin n_fail++; $display("FAIL drain_q[%0d]: got %h expected %h", i, q, sb_a[0]); end
      cyc();
    end
    ren = 1'b0;
    n_checks += 4;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", empty); end
    if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", count); end
    if (overflow !== ovf_a) begin n_fail++; $display("FAIL ovf_sticky: got %b expected %b", overflow, ovf_a); end
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL drain_udf: got %b expected 0", underflow); end
  endtask

  task automatic test_underflow();
    d = 8'hA5; wen = 1'b1; ren = 1'b1;
    cyc();
    wen = 1'b0;
    n_checks += 3;
    if (count !== 3'd1) begin n_fail++; $display("FAIL udf_count: got %0d expected 1", count); end
    if (q !== 8'hA5) begin n_fail++; $display("FAIL udf_q: got %h expected a5", q); end
    if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_flag: got %b expected 1", underflow); end
    cyc();
    ren = 1'b0;
    n_checks += 3;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL udf_empty: got %b expected 1", empty); end
    if (count !== 3'd0) begin n_fail++; $display("FAIL udf_count2: got %0d expected 0", count); end
    if (underflow !== udf_a) begin n_fail++; $display("FAIL udf_sticky: got %b expected %b", underflow, udf_a); end
  endtask

  task automatic test_back_to_back();
    wen = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d = 8'(8'h60 + i);
      cyc();
    end
    ren = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = 8'(8'h62 + i);
      n_checks++;
      if (q !== sb_a[0]) begin n_fail++; $display("FAIL stream_q[%0d]: got %h expected %h", i, q, sb_a[0]); end
      cyc();
      n_checks += 4;
      if (count !== 3'd2) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 2", i, count); end
      if ({empty, full, almost_empty, almost_full} !== 4'b0000) begin
        n_fail++; $display("FAIL stream_flags[%0d]: got %b expected 0000", i, {empty, full, almost_empty, almost_full});
      end
      if (overflow !== ovf_a) begin n_fail++; $display("FAIL stream_ovf[%0d]: got %b expected %b", i, overflow, ovf_a); end
      if (underflow !== udf_a) begin n_fail++; $display("FAIL stream_udf[%0d]: got %b expected %b", i, underflow, udf_a); end
    end
    ren = 1'b0;
    d = 8'h90;
    cyc();
    wen = 1'b0;
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; wen = 1'b1; ren = 1'b1; d = 8'h99;
    cyc();
    rst = 1'b0; ren = 1'b0;
    n_checks += 4;
    if (count !== 3'd0) begin n_fail++; $display("FAIL mrst_count: got %0d expected 0", count); end
    if (empty !== 1'b1) begin n_fail++; $display("FAIL mrst_empty: got %b expected 1", empty); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL mrst_ovf: got %b expected 0", overflow); end
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL mrst_udf: got %b expected 0", underflow); end
    d = 8'h7E;
    cyc();
    wen = 1'b0;
    n_checks += 3;
    if (q !== 8'h7E) begin n_fail++; $display("FAIL mrst_q: got %h expected 7e", q); end
    if (empty !== 1'b0) begin n_fail++; $display("FAIL mrst_empty2: got %b expected 0", empty); end
    if (count !== 3'(sb_a.size())) begin n_fail++; $display("FAIL mrst_count2: got %0d expected %0d", count, sb_a.size()); end
  endtask

  task automatic test_degenerate();
    logic [1:0] wr [5] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b01};
    logic [7:0] dv [5] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h00};
    for (int i = 0; i < 5; i++) begin
      wen1 = wr[i][1]; ren1 = wr[i][0]; d1 = dv[i];
      cyc();
      n_checks += 4;
      if (count1 !== 2'(sb_b.size())) begin n_fail++; $display("FAIL deg_count[%0d]: got %0d expected %0d", i, count1, sb_b.size()); end
      if (full1 !== (sb_b.size() == 2)) begin n_fail++; $display("FAIL deg_full[%0d]: got %b expected %b", i, full1, sb_b.size() == 2); end
      if (overflow1 !== ovf_b) begin n_fail++; $display("FAIL deg_ovf[%0d]: got %b expected %b", i, overflow1, ovf_b); end
      if (sb_b.size() > 0 && q1 !== sb_b[0]) begin n_fail++; $display("FAIL deg_q[%0d]: got %h expected %h", i, q1, sb_b[0]); end
    end
    wen1 = 1'b0; ren1 = 1'b0;
    n_checks += 2;
    if (q1 !== 8'h03) begin n_fail++; $display("FAIL deg_last_q: got %h expected 03", q1); end
    if (underflow1 !== 1'b0) begin n_fail++; $display("FAIL deg_udf: got %b expected 0", underflow1); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_mid_reset();
    test_degenerate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
